dmem_ctrl: RTL and testbench

//  Multi-cycle main data-memory model and controller that sits directly downstream of the beta cache.

---
 rtl/beta_pkg.sv | 20 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// beta_pkg: shared types and defaults for the beta data-memory controller.
//   dmem_state_t          - controller FSM states
//   DMEM_LATENCY_DEFAULT  - default access latency in cycles
//   DMEM_DEPTH_DEFAULT    - default backing-store depth in 32-bit words
//   DMEM_DATA_W           - data word width
package beta_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } dmem_state_t;

    localparam int unsigned DMEM_LATENCY_DEFAULT = 4;
    localparam int unsigned DMEM_DEPTH_DEFAULT   = 1024;
    localparam int unsigned DMEM_DATA_W          = 32;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32-bit word store, synchronous write, combinational read.
// Contents are deliberately not reset.
// Ports:
//   clk_i    in   clock
//   we_i     in   write enable, sampled on rising edge
//   addr_i   in   word index shared by the read and write paths
//   wdata_i  in   write data
//   rdata_o  out  store[addr_i], combinational
module dmem_array
    import beta_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [DMEM_DATA_W-1:0] wdata_i,
    output logic [DMEM_DATA_W-1:0] rdata_o
);

    logic [DMEM_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory controller behind the beta cache.
// Serialises one read or write at a time; completion strobe rises exactly LATENCY cycles
// after the request is captured. Write wins over a simultaneous read.
// Optional build macro DMEM_ALIGN_CHECK_EN adds memMisaligned: misaligned writes are dropped
// (handshake still completes) and misaligned reads return zero.
// Ports:
//   clk            in   clock
//   reset          in   asynchronous active-low reset
//   MemRead        in   read request (miss fill)
//   MemReadDone    in   cache has consumed read data
//   MemWriteReady  in   write request, held until MemWriteDone is seen
//   memAddr        in   byte address; word index = memAddr[$clog2(DEPTH)+1:2]
//   memWriteData   in   write data
//   memReadData    out  read data, valid while MemReadReady
//   MemReadReady   out  read data available
//   MemWriteDone   out  write committed
//   memMisaligned  out  (DMEM_ALIGN_CHECK_EN only) current access has memAddr[1:0] != 0
module dmem_ctrl
    import beta_pkg::*;
#(
    parameter int unsigned DEPTH   = DMEM_DEPTH_DEFAULT,
    parameter int unsigned LATENCY = DMEM_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemReadDone,
    input  logic        MemWriteReady,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWriteData,
    output logic [31:0] memReadData,
    output logic        MemReadReady,
    output logic        MemWriteDone
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        memMisaligned
`endif
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] LatM1 = CntW'(LATENCY - 1);

    dmem_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            rd_ready_q, rd_ready_d;
    logic            wr_done_q, wr_done_d;
`ifdef DMEM_ALIGN_CHECK_EN
    logic            mis_q, mis_d;
`endif

    logic        mem_we;
    logic [31:0] mem_rdata;

    // Address bits outside the word index carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^{memAddr[31:AW+2], memAddr[1:0]};

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_ready_d = rd_ready_q;
        wr_done_d  = wr_done_q;
        mem_we     = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        mis_d      = mis_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (MemWriteReady) begin
                    idx_d   = memAddr[AW+1:2];
                    wdata_d = memWriteData;
                    cnt_d   = LatM1;
                    state_d = WR_WAIT;
`ifdef DMEM_ALIGN_CHECK_EN
                    mis_d   = |memAddr[1:0];
`endif
                end else if (MemRead && !MemReadDone) begin
                    idx_d   = memAddr[AW+1:2];
                    cnt_d   = LatM1;
                    state_d = RD_WAIT;
`ifdef DMEM_ALIGN_CHECK_EN
                    mis_d   = |memAddr[1:0];
`endif
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    rd_data_d  = mem_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
                    if (mis_q) begin
                        rd_data_d = '0;
                    end
`endif
                    rd_ready_d = 1'b1;
                    state_d    = RD_RESP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            RD_RESP: begin
                if (MemReadDone) begin
                    rd_ready_d = 1'b0;
                    rd_data_d  = '0;
                    state_d    = IDLE;
`ifdef DMEM_ALIGN_CHECK_EN
                    mis_d      = 1'b0;
`endif
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
                    // Misaligned writes still handshake but never touch the store.
                    if (mis_q) begin
                        mem_we = 1'b0;
                    end
`endif
                    wr_done_d = 1'b1;
                    state_d   = WR_RESP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            WR_RESP: begin
                if (!MemWriteReady) begin
                    wr_done_d = 1'b0;
                    state_d   = IDLE;
`ifdef DMEM_ALIGN_CHECK_EN
                    mis_d     = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset leaves the store untouched; a write still in WR_WAIT never reaches mem_we.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_ready_q <= 1'b0;
            wr_done_q  <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_ready_q <= rd_ready_d;
            wr_done_q  <= wr_done_d;
`ifdef DMEM_ALIGN_CHECK_EN
            mis_q      <= mis_d;
`endif
        end
    end

    assign memReadData  = rd_data_q;
    assign MemReadReady = rd_ready_q;
    assign MemWriteDone = wr_done_q;
`ifdef DMEM_ALIGN_CHECK_EN
    assign memMisaligned = mis_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl (DEPTH=1024, LATENCY=4).
module tb_dmem_ctrl;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 4;
    localparam int          MAX_WAIT = 20;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemReadDone;
    logic        MemWriteReady;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        MemReadReady;
    logic        MemWriteDone;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        memMisaligned;
`endif

    dmem_ctrl #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead       (MemRead),
        .MemReadDone   (MemReadDone),
        .MemWriteReady (MemWriteReady),
        .memAddr       (memAddr),
        .memWriteData  (memWriteData),
        .memReadData   (memReadData),
        .MemReadReady  (MemReadReady),
        .MemWriteDone  (MemWriteDone)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .memMisaligned (memMisaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] sb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    function automatic logic misal(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write handshake; inputs scrambled after capture to prove latching.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        int cyc;
        memAddr       = addr;
        memWriteData  = data;
        MemWriteReady = 1'b1;
        tick();
        memAddr      = ~addr;
        memWriteData = ~data;
        cyc = 0;
        while (!MemWriteDone && cyc < MAX_WAIT) begin
            tick();
            cyc++;
        end
        check_eq("wr_latency", 32'(cyc), 32'(LATENCY));
        if (!misal(addr)) model_mem[widx(addr)] = data;
        tick();
        tick();
        check_eq("wr_done_hold", {31'b0, MemWriteDone}, 32'd1);
        check_eq("wr_no_rd_strobe", {31'b0, MemReadReady}, 32'd0);
        MemWriteReady = 1'b0;
        tick();
        check_eq("wr_done_drop", {31'b0, MemWriteDone}, 32'd0);
    endtask

    // Full read handshake; expected data queued at request time, popped on MemReadReady.
    task automatic do_read(input logic [31:0] addr, input int hold);
        int cyc;
        int bad;
        logic [31:0] exp;
        logic [31:0] first;
        memAddr     = addr;
        MemRead     = 1'b1;
        MemReadDone = 1'b0;
        sb_q.push_back(misal(addr) ? 32'h0 : model_mem[widx(addr)]);
        tick();
        memAddr = ~addr;
        MemRead = 1'b0;
        cyc = 0;
        while (!MemReadReady && cyc < MAX_WAIT) begin
            tick();
            cyc++;
        end
        check_eq("rd_latency", 32'(cyc), 32'(LATENCY));
        exp = sb_q.pop_front();
        check_eq("rd_data", memReadData, exp);
        if (hold > 0) begin
            first = memReadData;
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (!MemReadReady || memReadData !== first || MemWriteDone) bad++;
            end
            check_eq("rd_hold_stable", 32'(bad), 32'd0);
        end
        MemReadDone = 1'b1;
        tick();
        check_eq("rd_ready_drop", {31'b0, MemReadReady}, 32'd0);
        MemReadDone = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [31:0] exp;
        reset         = 1'b0;
        MemRead       = 1'b0;
        MemReadDone   = 1'b0;
        MemWriteReady = 1'b0;
        memAddr       = '0;
        memWriteData  = '0;
        tick();
        tick();
        check_eq("rst_rd_data", memReadData, 32'h0);
        check_eq("rst_rd_ready", {31'b0, MemReadReady}, 32'd0);
        check_eq("rst_wr_done", {31'b0, MemWriteDone}, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
        check_eq("rst_misaligned", {31'b0, memMisaligned}, 32'd0);
`endif
        reset = 1'b1;
        tick();

        // Write then read, with a long read hold.
        do_write(32'h40, 32'hDEADBEEF);
        do_read(32'h40, 10);
        do_write(32'h44, 32'h0BADF00D);
        do_read(32'h44, 0);
        do_read(32'h40, 2);
        // Low address bits ignored (or zeroed when alignment checking is on).
        do_read(32'h42, 0);

        // Address wrap modulo DEPTH.
        do_write(32'h1000, 32'h12345678);
        do_read(32'h0, 0);

        // Simultaneous request: write first, then the read sees the new data.
        memAddr       = 32'h200;
        memWriteData  = 32'hA5A55A5A;
        MemWriteReady = 1'b1;
        MemRead       = 1'b1;
        MemReadDone   = 1'b0;
        model_mem[widx(32'h200)] = 32'hA5A55A5A;
        sb_q.push_back(32'hA5A55A5A);
        cyc = 0;
        while (!MemWriteDone && !MemReadReady && cyc < MAX_WAIT) begin
            tick();
            cyc++;
        end
        check_eq("sim_write_first", {31'b0, MemWriteDone}, 32'd1);
        check_eq("sim_no_read_yet", {31'b0, MemReadReady}, 32'd0);
        MemWriteReady = 1'b0;
        cyc = 0;
        while (!MemReadReady && cyc < MAX_WAIT) begin
            tick();
            cyc++;
        end
        check_eq("sim_read_ready", {31'b0, MemReadReady}, 32'd1);
        exp = sb_q.pop_front();
        check_eq("sim_read_data", memReadData, exp);
        MemRead     = 1'b0;
        MemReadDone = 1'b1;
        tick();
        MemReadDone = 1'b0;
        tick();

        // Reset while in RD_WAIT.
        memAddr = 32'h40;
        MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check_eq("abort_rdwait_ready", {31'b0, MemReadReady}, 32'd0);
        check_eq("abort_rdwait_data", memReadData, 32'h0);
        tick();
        reset = 1'b1;
        do_read(32'h40, 0);

        // Reset while in RD_RESP: outputs clear asynchronously.
        memAddr = 32'h44;
        MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
        cyc = 0;
        while (!MemReadReady && cyc < MAX_WAIT) begin
            tick();
            cyc++;
        end
        check_eq("rdresp_reached", {31'b0, MemReadReady}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("abort_rdresp_ready", {31'b0, MemReadReady}, 32'd0);
        check_eq("abort_rdresp_data", memReadData, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Reset during WR_WAIT: write must not commit.
        do_write(32'h80, 32'h11112222);
        memAddr       = 32'h80;
        memWriteData  = 32'hCAFEF00D;
        MemWriteReady = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        MemWriteReady = 1'b0;
        #1;
        check_eq("abort_wr_done", {31'b0, MemWriteDone}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        do_read(32'h80, 0);

`ifdef DMEM_ALIGN_CHECK_EN
        memAddr       = 32'h81;
        memWriteData  = 32'hFFFFFFFF;
        MemWriteReady = 1'b1;
        tick();
        check_eq("misaligned_flag", {31'b0, memMisaligned}, 32'd1);
        cyc = 0;
        while (!MemWriteDone && cyc < MAX_WAIT) begin
            tick();
            cyc++;
        end
        check_eq("misaligned_wr_done", {31'b0, MemWriteDone}, 32'd1);
        MemWriteReady = 1'b0;
        tick();
        check_eq("misaligned_clear", {31'b0, memMisaligned}, 32'd0);
        do_read(32'h80, 0);
        do_read(32'h81, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
